peg_row_scanner: RTL
====================

// Module: peg_row_scanner
// PURPOSE
//  Parametrised pixel-offset generator for a horizontal row of equal square cells, e.g. feedback pegs or code pegs.
//  Replaces the fixed-size square counters with a start/done FSM. Uses nested counters, with no divide or modulo.
//  Sits between the game-control FSM and the VGA adapter. The caller adds x/y to the row origin and picks the colour from lit.
// PARAMETERS
//  CELL_W     4  cell width in pixels (>=1)
//  CELL_H     4  cell height in pixels (>=1)
//  GAP        2  horizontal blank pixels between adjacent cells (>=0)
//  MAX_CELLS  4  cells in the row (>=1)
//  localparams: XW=clog2(MAX_CELLS*(CELL_W+GAP)), YW=clog2(CELL_H), CW=clog2(MAX_CELLS+1), IW=clog2(MAX_CELLS), each min 1
// PORTS
//  clock       in   1   single clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  start       in   1   begin a scan; sampled only in IDLE
//  count       in   CW  number of lit cells; latched on accepted start
//  erase_rest  in   1   1: also scan cells >=count with lit=0; 0: skip them. Latched on start
//  hold        in   1   stall; freezes all counters, plot=0
//  x           out  XW  pixel x offset within row
//  y           out  YW  pixel y offset within row
//  cell_idx    out  IW  cell currently being scanned
//  lit         out  1   1 if cell_idx < latched count
//  plot        out  1   x/y/lit valid this cycle; pixel consumed when high
//  busy        out  1   high in SCAN and DONE
//  done        out  1   one-cycle pulse after last pixel
// BEHAVIOUR
//  Reset: FSM=IDLE; x=0, y=0, cell_idx=0, lit=0, plot=0, busy=0, done=0. Applies mid-scan too: no done pulse, scan abandoned.
//  FSM IDLE->SCAN on start; SCAN->DONE after last pixel consumed; DONE->IDLE unconditionally (done=1 only in DONE).
//  IDLE+start: count saturates to MAX_CELLS when count>MAX_CELLS.
//    limit = erase_rest ? MAX_CELLS : count_sat.
//    limit==0 -> go IDLE->DONE directly, no plot.
//  start while busy: ignored.
//  Scan order: col fastest (0..CELL_W-1), then cell (0..limit-1), then row (0..CELL_H-1).
//  x = cell*(CELL_W+GAP)+col, kept as a running x register. On cell advance, add GAP+1. On row wrap, load 0. No multiplier.
//  Gap pixels cost zero cycles and are never plotted.
//  plot = (state==SCAN) & ~hold. Counters advance only on cycles with plot=1.
//  First plot is the cycle after start is accepted. A scan takes exactly limit*CELL_W*CELL_H plot cycles plus hold cycles.
//  Last pixel is (x=(limit-1)*(CELL_W+GAP)+CELL_W-1, y=CELL_H-1). The DONE cycle follows it. Counters return to 0 in DONE.
//  hold in IDLE/DONE has no effect. hold on the last-pixel cycle delays DONE.
//  lit is updated on cell change, in the same cycle as the new cell_idx.
// STRUCTURE
//  Shared header draw_defs.vh: FSM state encodings (IDLE/SCAN/DONE), clog2 helper function, default cell geometry constants.
//  One sub-module: wrap_counter #(MAX) with inc/clear/wrap outputs. Used three times: col, cell, row.
//    cell wrap compares against runtime limit, so it gets a max input port.
//  Everything else (FSM, x accumulator, lit compare) lives in this module.
// TESTING (defaults CELL_W=4 CELL_H=4 GAP=2 MAX_CELLS=4)
//  1 reset, start count=2 erase_rest=0 -> 32 plots.
//    Row 0 x=0..3,6..9; first (0,0), last (9,3); all lit=1.
//    done pulse on cycle 33 after start; busy low after.
//  2 start count=0 erase_rest=0 -> plot never high; done one cycle after start.
//  3 start count=1 erase_rest=1 -> 64 plots, last (21,3).
//    lit=1 only for x 0..3; cell_idx 1..3 have lit=0.
//  4 start count=7 erase_rest=0 -> saturates to 4: 64 plots, all lit=1, max x=21.
//  5 count=4, hold high 3 cycles at the 10th pixel -> plot=0 and x/y frozen during hold.
//    Then resumes at the same pixel. No drop or duplicate. done delayed 3 cycles.
//  6 reset high at 20th pixel -> next cycle plot=0, busy=0, no done.
//    start pulse during busy (separate run) ignored. Fresh start after reset runs cleanly from (0,0).

Source files
------------

// File: rtl/peg_row_scanner_pkg.sv
// Shared types and helpers for the peg row scanner.
// FSM encodings, width helper and default cell geometry.
package peg_row_scanner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_e;

   localparam int DEF_CELL_W    = 4;
   localparam int DEF_CELL_H    = 4;
   localparam int DEF_GAP       = 2;
   localparam int DEF_MAX_CELLS = 4;

   function automatic int clog2_min1(input int v);
      int r;
      r = $clog2(v);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/peg_row_scanner_wrap.sv
// Wrapping up-counter with clear, runtime terminal value and wrap strobe.
// wrap_o fires on the increment that takes the count from max_i back to 0.
module wrap_counter
   import peg_row_scanner_pkg::*;
#(
   parameter int MAX = 4,
   localparam int W  = clog2_min1(MAX)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         inc_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] q_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap_o = inc_i & (cnt_q == max_i);
   assign q_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (wrap_o)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/peg_row_scanner.sv
// Pixel-offset generator for a row of equal square cells.
// Nested col/cell/row counters plus a running x accumulator.
module peg_row_scanner
   import peg_row_scanner_pkg::*;
#(
   parameter int CELL_W    = DEF_CELL_W,
   parameter int CELL_H    = DEF_CELL_H,
   parameter int GAP       = DEF_GAP,
   parameter int MAX_CELLS = DEF_MAX_CELLS,
   localparam int XW = clog2_min1(MAX_CELLS * (CELL_W + GAP)),
   localparam int YW = clog2_min1(CELL_H),
   localparam int CW = clog2_min1(MAX_CELLS + 1),
   localparam int IW = clog2_min1(MAX_CELLS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] count,
   input  logic          erase_rest,
   input  logic          hold,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [IW-1:0] cell_idx,
   output logic          lit,
   output logic          plot,
   output logic          busy,
   output logic          done
);

   localparam int COLW = clog2_min1(CELL_W);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] last_q, last_d;
   logic [XW-1:0] x_q, x_d;
   logic          lit_q, lit_d;

   logic [CW-1:0]   count_sat, limit;
   logic [COLW-1:0] col;
   logic            col_wrap, cell_wrap, row_wrap;
   logic            clr;

   assign plot     = (state_q == SCAN) & ~hold;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign clr      = (state_q != SCAN);
   assign x        = x_q;
   assign lit      = lit_q;

   wrap_counter #(.MAX(CELL_W)) u_col (
      .clock   (clock),
      .reset   (reset),
      .clear_i (clr),
      .inc_i   (plot),
      .max_i   (COLW'(CELL_W - 1)),
      .q_o     (col),
      .wrap_o  (col_wrap)
   );

   wrap_counter #(.MAX(MAX_CELLS)) u_cell (
      .clock   (clock),
      .reset   (reset),
      .clear_i (clr),
      .inc_i   (col_wrap),
      .max_i   (last_q),
      .q_o     (cell_idx),
      .wrap_o  (cell_wrap)
   );

   wrap_counter #(.MAX(CELL_H)) u_row (
      .clock   (clock),
      .reset   (reset),
      .clear_i (clr),
      .inc_i   (cell_wrap),
      .max_i   (YW'(CELL_H - 1)),
      .q_o     (y),
      .wrap_o  (row_wrap)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      x_d       = x_q;
      lit_d     = lit_q;
      count_sat = (count > CW'(MAX_CELLS)) ? CW'(MAX_CELLS) : count;
      limit     = erase_rest ? CW'(MAX_CELLS) : count_sat;
      unique case (state_q)
         IDLE: begin
            x_d   = '0;
            lit_d = 1'b0;
            if (start) begin
               cnt_d   = count_sat;
               last_d  = IW'(limit - 1'b1);
               lit_d   = (count_sat != '0);
               state_d = (limit == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (plot) begin
               if (cell_wrap) begin
                  x_d   = '0;
                  lit_d = (cnt_q != '0);
               end else if (col_wrap) begin
                  // skip the gap in the same cycle as the cell advance
                  x_d   = x_q + XW'(GAP + 1);
                  lit_d = (CW'(cell_idx + 1'b1) < cnt_q);
               end else begin
                  x_d = x_q + 1'b1;
               end
               if (row_wrap)
                  state_d = DONE;
            end
         end
         DONE: begin
            x_d     = '0;
            lit_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= '0;
         x_q     <= '0;
         lit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         x_q     <= x_d;
         lit_q   <= lit_d;
      end
   end

endmodule
